// File: rtl/uart_rx.sv
// 8N1 UART receiver with status/data word; define UART_RX_FIFO_EN for a
// FIFO_DEPTH-entry receive FIFO instead of a single holding register.
module uart_rx #(
  parameter logic [11:0] BIT_TIME   = 12'd433,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] din,
  output logic [31:0] dout,
  input  logic        wr,
  input  logic        valid,
  input  logic        rxd
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  localparam logic [11:0] HALF = BIT_TIME >> 1;

  state_t      state_q;
  logic [11:0] tdiv_q;
  logic [2:0]  bit_q;
  logic [7:0]  shreg_q;
  logic        sync_q, rxs_q, rxs_prev_q;
  logic        ferr_q, ovr_q;

  logic        bit_end;
  logic        push, bad_stop, pop;
  logic        avail, full;
  logic        push_ok, ovr_set;
  logic [7:0]  head;
  logic        unused_ok;

  assign bit_end  = (tdiv_q == BIT_TIME);
  assign push     = (state_q == S_STOP) && bit_end && rxs_q;
  assign bad_stop = (state_q == S_STOP) && bit_end && !rxs_q;
  assign pop      = valid && !wr && avail;
  assign push_ok  = push && (!full || pop);
  assign ovr_set  = push && full && !pop;
  assign unused_ok = ^din[31:2] ^ (FIFO_DEPTH == 0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tdiv_q     <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      sync_q     <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync_q     <= rxd;
      rxs_q      <= sync_q;
      rxs_prev_q <= rxs_q;
      if (state_q == S_IDLE || bit_end) tdiv_q <= '0;
      else                              tdiv_q <= tdiv_q + 12'd1;
      unique case (state_q)
        S_IDLE: begin
          if (rxs_prev_q && !rxs_q) begin
            state_q <= S_START;
            tdiv_q  <= '0;
          end
        end
        S_START: begin
          // restart the divider here so later samples land mid-bit
          if (tdiv_q == HALF) begin
            tdiv_q  <= '0;
            bit_q   <= '0;
            state_q <= rxs_q ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            shreg_q <= {rxs_q, shreg_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= S_STOP;
          end
        end
        S_STOP: begin
          if (bit_end) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef UART_RX_FIFO_EN
  localparam int unsigned AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned AW1 = AW + 1;
  localparam logic [AW:0] FULL_CNT = AW1'(FIFO_DEPTH);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] rp_q, wp_q;
  logic [AW:0]   cnt_q;

  assign avail = (cnt_q != '0);
  assign full  = (cnt_q == FULL_CNT);
  assign head  = mem_q[rp_q];

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wp_q] <= shreg_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rp_q  <= '0;
      wp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wp_q <= wp_q + 1'b1;
      if (pop)     rp_q <= rp_q + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
`else
  logic [7:0] hold_q;
  logic       ready_q;

  assign avail = ready_q;
  assign full  = ready_q;
  assign head  = hold_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      if (push_ok)  hold_q  <= shreg_q;
      if (push_ok)  ready_q <= 1'b1;
      else if (pop) ready_q <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
      dout   <= '0;
    end else begin
      if (bad_stop)                ferr_q <= 1'b1;
      else if (valid && wr && din[0]) ferr_q <= 1'b0;
      if (ovr_set)                 ovr_q  <= 1'b1;
      else if (valid && wr && din[1]) ovr_q  <= 1'b0;
      dout <= {20'b0, state_q != S_IDLE, ovr_q, ferr_q, avail,
               avail ? head : 8'h00};
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at BIT_TIME=15 (16 clk per bit).
// Works with or without UART_RX_FIFO_EN defined.
module tb_uart_rx;

`ifdef UART_RX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        wr = 1'b0;
  logic        valid = 1'b0;
  logic        rxd = 1'b1;

  int         errs = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  logic       e_ferr = 1'b0;
  logic       e_ovr = 1'b0;

  uart_rx #(.BIT_TIME(12'd15), .FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .dout  (dout),
    .wr    (wr),
    .valid (valid),
    .rxd   (rxd)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_status(input logic busy);
    logic [7:0] h;
    h = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
    return {20'b0, busy, e_ovr, e_ferr, exp_q.size() != 0, h};
  endfunction

  // drives one frame starting at a negedge; rd=1 reads in the push cycle
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input bit rd);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rxd = bits[k];
      for (int i = 1; i <= 16; i++) begin
        @(negedge clk);
        if (rd && k == 9 && i == 10) begin
          valid = 1'b1;
          wr    = 1'b0;
        end
        if (rd && k == 9 && i == 11) begin
          valid = 1'b0;
          chk("rd_at_stop", dout, exp_status(1'b1));
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
      end
    end
    if (stop) begin
      if (exp_q.size() < CAP) exp_q.push_back(b);
      else                    e_ovr = 1'b1;
    end else begin
      e_ferr = 1'b1;
    end
  endtask

  task automatic rd_byte(input string tag);
    valid = 1'b1;
    wr    = 1'b0;
    @(negedge clk);
    valid = 1'b0;
    chk(tag, dout, exp_status(1'b0));
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    @(negedge clk);
    chk({tag, "_post"}, dout, exp_status(1'b0));
  endtask

  task automatic wr_ctl(input string tag, input logic [31:0] d);
    valid = 1'b1;
    wr    = 1'b1;
    din   = d;
    @(negedge clk);
    valid = 1'b0;
    wr    = 1'b0;
    din   = '0;
    if (d[0]) e_ferr = 1'b0;
    if (d[1]) e_ovr  = 1'b0;
    @(negedge clk);
    chk(tag, dout, exp_status(1'b0));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset", dout, 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle", dout, exp_status(1'b0));

    send_frame(8'hA5, 1'b1, 1'b0);
    chk("rx_a5", dout, exp_status(1'b0));
    rd_byte("rd_a5");

    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    chk("glitch_busy", dout, exp_status(1'b1));
    repeat (30) @(negedge clk);
    chk("glitch_idle", dout, exp_status(1'b0));

    send_frame(8'h3C, 1'b0, 1'b0);
    chk("ferr_set", dout, exp_status(1'b0));
    rxd = 1'b1;
    repeat (16) @(negedge clk);
    chk("ferr_hold", dout, exp_status(1'b0));
    wr_ctl("ferr_clr", 32'h1);

`ifdef UART_RX_FIFO_EN
    for (int n = 1; n <= 5; n++) send_frame(8'(n), 1'b1, 1'b0);
`else
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
`endif
    chk("ovr_set", dout, exp_status(1'b0));
    for (int n = 0; n <= CAP; n++) rd_byte("rd_ovr");
    wr_ctl("ovr_clr", 32'h2);

    send_frame(8'h66, 1'b1, 1'b0);
    chk("rx_66", dout, exp_status(1'b0));
    send_frame(8'h77, 1'b1, 1'b1);
    chk("rx_77", dout, exp_status(1'b0));
    rd_byte("rd_77");

    rxd = 1'b0;
    repeat (16) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    chk("mid_busy", dout, exp_status(1'b1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    e_ferr = 1'b0;
    e_ovr  = 1'b0;
    chk("rst_mid", dout, 32'h0);
    @(negedge clk);
    chk("rst_mid_1", dout, exp_status(1'b0));
    repeat (200) @(negedge clk);
    chk("rst_no_byte", dout, exp_status(1'b0));

    send_frame(8'h5A, 1'b1, 1'b0);
    chk("rx_5a", dout, exp_status(1'b0));
    rd_byte("rd_5a");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
